// File: rtl/adc_acq_ctrl.sv
// adc_acq_ctrl: paced single-shot ADC acquisition with a show-ahead sample FIFO toward the framer.
// Optional Conv_Done watchdog and Timeout_Err port are built in when ACQ_TIMEOUT_EN is defined.
module adc_acq_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned DIV_W  = 8
`ifdef ACQ_TIMEOUT_EN
  ,
  parameter int unsigned TMO    = 15
`endif
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic              Abort,
  input  logic [CNT_W-1:0]  Num_Samples,
  input  logic [DIV_W-1:0]  Div,
  output logic              En_Conv,
  input  logic              Conv_Done,
  input  logic [DATA_W-1:0] Adc_Data,
  output logic [DATA_W-1:0] M_Data,
  output logic              M_Valid,
  input  logic              M_Ready,
  output logic              M_Last,
  output logic              Busy,
  output logic              Done
`ifdef ACQ_TIMEOUT_EN
  ,
  output logic              Timeout_Err
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StConv, StWait} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     num_q, num_d;
  logic [CNT_W-1:0]     smp_cnt_q, smp_cnt_d;
  logic [DIV_W-1:0]     div_eff_q, div_eff_d;
  logic [DIV_W-1:0]     elapsed_q, elapsed_d;
  logic                 done_q, done_d;
  logic [PTR_W:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W:0]      fifo_mem [DEPTH];
  logic [PTR_W:0]       fifo_cnt;
  logic [DATA_W:0]      fifo_head;
  logic                 has_space;
  logic                 is_last;
  logic                 push;
  logic                 pop;
`ifdef ACQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TMO + 1);
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic                 tmo_err_q, tmo_err_d;
`endif

  assign fifo_cnt  = wr_ptr_q - rd_ptr_q;
  assign fifo_head = fifo_mem[rd_ptr_q[PTR_W-1:0]];
  assign has_space = (fifo_cnt != (PTR_W+1)'(DEPTH));
  assign is_last   = (smp_cnt_q == num_q - CNT_W'(1));
  // Only the first Conv_Done cycle inside CONV is taken; Abort discards it.
  assign push      = (state_q == StConv) && Conv_Done && !Abort;
  assign pop       = (fifo_cnt != '0) && M_Ready;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= StIdle;
      num_q     <= '0;
      smp_cnt_q <= '0;
      div_eff_q <= '0;
      elapsed_q <= '0;
      done_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
`ifdef ACQ_TIMEOUT_EN
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      smp_cnt_q <= smp_cnt_d;
      div_eff_q <= div_eff_d;
      elapsed_q <= elapsed_d;
      done_q    <= done_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
`ifdef ACQ_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {is_last, Adc_Data};
    end
  end

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    smp_cnt_d = smp_cnt_q;
    div_eff_d = div_eff_q;
    done_d    = 1'b0;
    // Cycles since the last En_Conv, saturating so long stalls cannot wrap.
    elapsed_d = (elapsed_q == '1) ? elapsed_q : elapsed_q + DIV_W'(1);
    wr_ptr_d  = wr_ptr_q + (PTR_W+1)'(push);
    rd_ptr_d  = rd_ptr_q + (PTR_W+1)'(pop);
`ifdef ACQ_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    tmo_err_d = tmo_err_q;
`endif
    if (Abort) begin
      state_d  = StIdle;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (Start) begin
`ifdef ACQ_TIMEOUT_EN
            tmo_err_d = 1'b0;
`endif
            if (Num_Samples != '0) begin
              state_d   = StIssue;
              num_d     = Num_Samples;
              smp_cnt_d = '0;
              div_eff_d = (Div < DIV_W'(4)) ? DIV_W'(4) : Div;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        StIssue: begin
          if (has_space) begin
            state_d   = StConv;
            elapsed_d = DIV_W'(1);
`ifdef ACQ_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
          end
        end
        StConv: begin
          if (Conv_Done) begin
            smp_cnt_d = smp_cnt_q + CNT_W'(1);
            if (is_last) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              state_d = StWait;
            end
          end
`ifdef ACQ_TIMEOUT_EN
          else if (tmo_cnt_q == TMO_W'(TMO - 1)) begin
            state_d   = StIdle;
            tmo_err_d = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          end
`endif
        end
        StWait: begin
          if (elapsed_q >= div_eff_q - DIV_W'(1)) begin
            state_d = StIssue;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    En_Conv = (state_q == StIssue) && has_space && !Abort;
    Busy    = (state_q != StIdle);
    Done    = done_q;
    M_Valid = (fifo_cnt != '0);
    M_Data  = M_Valid ? fifo_head[DATA_W-1:0] : '0;
    M_Last  = M_Valid ? fifo_head[DATA_W] : 1'b0;
`ifdef ACQ_TIMEOUT_EN
    Timeout_Err = tmo_err_q;
`endif
  end

endmodule

// File: tb/tb_adc_acq_ctrl.sv
// tb_adc_acq_ctrl: directed scenarios plus a queue-based stream/busy/done model checked every cycle.
// Define ACQ_TIMEOUT_EN to also exercise the Conv_Done watchdog.
module tb_adc_acq_ctrl;

  localparam int DEPTH = 16;
`ifdef ACQ_TIMEOUT_EN
  localparam int TMO = 15;
`endif

  typedef struct packed {logic last; logic [7:0] data;} beat_t;

  logic        Clk;
  logic        Rst_n;
  logic        Start;
  logic        Abort;
  logic [15:0] Num_Samples;
  logic [7:0]  Div;
  logic        En_Conv;
  logic        Conv_Done;
  logic [7:0]  Adc_Data;
  logic [7:0]  M_Data;
  logic        M_Valid;
  logic        M_Ready;
  logic        M_Last;
  logic        Busy;
  logic        Done;
`ifdef ACQ_TIMEOUT_EN
  logic        Timeout_Err;
`endif

  adc_acq_ctrl dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .Start       (Start),
    .Abort       (Abort),
    .Num_Samples (Num_Samples),
    .Div         (Div),
    .En_Conv     (En_Conv),
    .Conv_Done   (Conv_Done),
    .Adc_Data    (Adc_Data),
    .M_Data      (M_Data),
    .M_Valid     (M_Valid),
    .M_Ready     (M_Ready),
    .M_Last      (M_Last),
    .Busy        (Busy),
    .Done        (Done)
`ifdef ACQ_TIMEOUT_EN
    ,
    .Timeout_Err (Timeout_Err)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;

  int    en_times[$];
  int    done_times[$];
  beat_t beats[$];

  // ADC responder knobs
  bit       adc_on     = 1'b1;
  int       resp_delay = 0;
  int       resp_hold  = 1;
  logic [7:0] adc_next = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic start_acq(input int num, input int dv, input bit clr);
    if (clr) begin
      en_times.delete();
      done_times.delete();
      beats.delete();
    end
    Num_Samples = 16'(num);
    Div         = 8'(dv);
    Start       = 1'b1;
    t0          = cyc;
    tick(1);
    Start       = 1'b0;
  endtask

  function automatic int en_at(input int i);
    return (i < en_times.size()) ? en_times[i] : -1;
  endfunction

  // Beats must be base, base+1, ... with M_Last on every last_every-th beat.
  task automatic check_stream(input string tag, input int n, input logic [7:0] base,
                              input int last_every);
    int errs = 0;
    check({tag, "_beats"}, beats.size(), n);
    for (int i = 0; i < beats.size(); i++) begin
      if (beats[i].data !== 8'(base + i)) errs++;
      if (beats[i].last !== (((i + 1) % last_every) == 0)) errs++;
    end
    check({tag, "_order"}, errs, 0);
  endtask

  always @(posedge Clk) cyc <= cyc + 1;

  // ADC capture stand-in: answers En_Conv after resp_delay cycles, holds Conv_Done resp_hold cycles.
  initial begin
    bit r_pend = 1'b0;
    int r_dly  = 0;
    int left   = 0;
    Conv_Done = 1'b0;
    Adc_Data  = 8'h00;
    forever begin
      @(negedge Clk);
      if (Rst_n && En_Conv && adc_on) begin
        r_pend = 1'b1;
        r_dly  = resp_delay;
      end
      @(posedge Clk);
      #1;
      if (left > 0) left--;
      if (left == 0) Conv_Done = 1'b0;
      if (r_pend) begin
        if (r_dly == 0) begin
          Conv_Done = 1'b1;
          Adc_Data  = adc_next;
          adc_next  = adc_next + 8'd1;
          left      = resp_hold;
          r_pend    = 1'b0;
        end else begin
          r_dly--;
        end
      end
    end
  end

  // Event recorder for the directed checks.
  always @(negedge Clk) begin
    if (Rst_n) begin
      if (En_Conv) en_times.push_back(cyc - t0);
      if (Done) done_times.push_back(cyc - t0);
      if (M_Valid && M_Ready) beats.push_back({M_Last, M_Data});
    end
  end

  // Behavioural model: one outstanding request at a time, a sample queue, and an acquisition index.
  initial begin
    beat_t mq[$];
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    bit m_pend = 1'b0;
    bit busy0;
    int m_idx  = 0;
    int m_num  = 0;
`ifdef ACQ_TIMEOUT_EN
    bit m_err  = 1'b0;
    int m_wait = 0;
`endif
    forever begin
      @(negedge Clk);
      if (Rst_n) begin
        check("busy", Busy, m_busy);
        check("done", Done, m_done);
        check("valid", M_Valid, mq.size() != 0);
        if (mq.size() != 0) begin
          check("data", M_Data, mq[0].data);
          check("last", M_Last, mq[0].last);
        end
`ifdef ACQ_TIMEOUT_EN
        check("tmo_err", Timeout_Err, m_err);
`endif
        if (En_Conv) check("en_legal", m_busy && !m_pend && mq.size() < DEPTH, 1'b1);
        busy0  = m_busy;
        m_done = 1'b0;
        if (Abort) begin
          mq.delete();
          m_busy = 1'b0;
          m_pend = 1'b0;
        end else begin
          if (M_Ready && mq.size() != 0) void'(mq.pop_front());
          if (m_pend) begin
            if (Conv_Done) begin
              mq.push_back({m_idx == m_num - 1, Adc_Data});
              m_pend = 1'b0;
              m_idx++;
              if (m_idx == m_num) begin
                m_busy = 1'b0;
                m_done = 1'b1;
              end
            end
`ifdef ACQ_TIMEOUT_EN
            else begin
              m_wait++;
              if (m_wait == TMO) begin
                m_busy = 1'b0;
                m_pend = 1'b0;
                m_err  = 1'b1;
              end
            end
`endif
          end
          if (En_Conv) begin
            m_pend = 1'b1;
`ifdef ACQ_TIMEOUT_EN
            m_wait = 0;
`endif
          end
          if (Start && !busy0) begin
`ifdef ACQ_TIMEOUT_EN
            m_err = 1'b0;
`endif
            if (Num_Samples != 16'd0) begin
              m_busy = 1'b1;
              m_num  = int'(Num_Samples);
              m_idx  = 0;
            end else begin
              m_done = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin
    Rst_n       = 1'b0;
    Start       = 1'b0;
    Abort       = 1'b0;
    Num_Samples = 16'd0;
    Div         = 8'd0;
    M_Ready     = 1'b0;
    tick(3);
    check("rst_en", En_Conv, 1'b0);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_valid", M_Valid, 1'b0);
    check("rst_data", M_Data, 8'h00);
    check("rst_last", M_Last, 1'b0);
    Rst_n = 1'b1;
    tick(2);

    // Basic paced acquisition
    M_Ready = 1'b1; adc_next = 8'h10;
    start_acq(3, 6, 1'b1);
    tick(30);
    check("t1_en_n", en_times.size(), 3);
    check("t1_en0", en_at(0), 1);
    check("t1_en1", en_at(1), 7);
    check("t1_en2", en_at(2), 13);
    check("t1_done_n", done_times.size(), 1);
    check("t1_done_t", (done_times.size() > 0) ? done_times[0] : -1, 15);
    check_stream("t1", 3, 8'h10, 3);

    // FIFO backpressure stall then drain
    M_Ready = 1'b0; adc_next = 8'h40;
    start_acq(20, 4, 1'b1);
    tick(100);
    check("t2_en_stall", en_times.size(), 16);
    check("t2_en15", en_at(15), 61);
    M_Ready = 1'b1;
    tick(100);
    check("t2_en_all", en_times.size(), 20);
    check_stream("t2", 20, 8'h40, 20);

    // Conv_Done held two cycles
    M_Ready = 1'b0; adc_next = 8'h70; resp_hold = 2;
    start_acq(5, 4, 1'b1);
    tick(40);
    check("t3_en_n", en_times.size(), 5);
    check("t3_done_t", (done_times.size() > 0) ? done_times[0] : -1, 19);
    M_Ready = 1'b1;
    tick(10);
    check_stream("t3", 5, 8'h70, 5);
    resp_hold = 1;

    // Abort while waiting on Conv_Done; the late answer must be dropped
    M_Ready = 1'b0; adc_next = 8'h90; resp_delay = 3;
    start_acq(4, 8, 1'b1);
    while (cyc < t0 + 11) tick(1);
    Abort = 1'b1;
    tick(1);
    Abort = 1'b0;
    check("t4_busy", Busy, 1'b0);
    check("t4_valid", M_Valid, 1'b0);
    tick(15);
    check("t4_valid_late", M_Valid, 1'b0);
    check("t4_en_n", en_times.size(), 2);
    check("t4_done_n", done_times.size(), 0);
    resp_delay = 0;
    M_Ready = 1'b1;
    tick(5);

    // Abort and Start together: Abort wins
    en_times.delete();
    Abort = 1'b1;
    start_acq(2, 4, 1'b0);
    Abort = 1'b0;
    check("t4b_busy", Busy, 1'b0);
    tick(8);
    check("t4b_en_n", en_times.size(), 0);

    // Zero-sample acquisition
    start_acq(0, 6, 1'b1);
    tick(10);
    check("t5_done_n", done_times.size(), 1);
    check("t5_done_t", (done_times.size() > 0) ? done_times[0] : -1, 1);
    check("t5_en_n", en_times.size(), 0);

    // Short Div clamps to 4
    for (int d = 0; d <= 2; d += 2) begin
      start_acq(3, d, 1'b1);
      tick(20);
      check("t6_en0", en_at(0), 1);
      check("t6_en1", en_at(1), 5);
      check("t6_en2", en_at(2), 9);
    end

    // Second Start appends behind undrained data
    M_Ready = 1'b0; adc_next = 8'hC0;
    start_acq(2, 4, 1'b1);
    tick(15);
    start_acq(2, 4, 1'b0);
    tick(15);
    M_Ready = 1'b1;
    tick(10);
    check("t7_done_n", done_times.size(), 2);
    check_stream("t7", 4, 8'hC0, 2);

`ifdef ACQ_TIMEOUT_EN
    // Conv_Done withheld
    adc_on = 1'b0;
    start_acq(2, 4, 1'b1);
    while (cyc < t0 + 16) tick(1);
    check("t8_err_early", Timeout_Err, 1'b0);
    tick(1);
    check("t8_err", Timeout_Err, 1'b1);
    check("t8_busy", Busy, 1'b0);
    check("t8_done_n", done_times.size(), 0);
    adc_on = 1'b1;
    start_acq(1, 4, 1'b1);
    check("t8_clr", Timeout_Err, 1'b0);
    tick(10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
